// File: rtl/pipelined_cla_adder_if.sv
// Bus bundle for the pipelined adder: operand input side and result output side.
// Each side is a valid/ready pair; a transfer happens on a rising edge where valid & ready are both 1.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             C0;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             OV;
    logic             Z;

    modport master (
        output in_valid, X, Y, C0, SUB, out_ready,
        input  in_ready, out_valid, S, CO, OV, Z
    );

    modport slave (
        input  in_valid, X, Y, C0, SUB, out_ready,
        output in_ready, out_valid, S, CO, OV, Z
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// WIDTH-bit add/subtract split into BLK-bit lookahead groups, one group per pipeline stage.
// Stage 0 registers the prepared operands; stage k+1 holds the result after group k.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_cla_adder_if.slave  bus
);
    localparam int NSTG = WIDTH / BLK;

    generate
        if (BLK < 1 || BLK > WIDTH || (WIDTH % BLK) != 0) begin : g_bad_param
            $error("pipelined_cla_adder: WIDTH must be a multiple of BLK and BLK in 1..WIDTH");
        end
    endgenerate

    // Every carry is a flat sum-of-products of the group inputs; nothing ripples.
    function automatic logic [BLK:0] cla_carries(input logic [BLK-1:0] p,
                                                 input logic [BLK-1:0] g,
                                                 input logic           cin);
        logic [BLK:0] c;
        logic         term;
        c = '0;
        for (int i = 0; i <= BLK; i++) begin
            term = cin;
            for (int j = 0; j < i; j++) term = term & p[j];
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    logic                 w_en;
    logic [NSTG:0]        r_vld;
    logic [WIDTH-1:0]     r_x [NSTG];
    logic [WIDTH-1:0]     r_y [NSTG];
    logic [WIDTH-1:0]     r_s [NSTG+1];
    logic [NSTG:0]        r_c;
    logic                 r_ov;
    logic                 r_z;
    logic [BLK-1:0]       w_p [NSTG];
    logic [BLK-1:0]       w_g [NSTG];
    logic [BLK:0]         w_c [NSTG];
    logic [WIDTH-1:0]     w_s [NSTG];

    // The whole pipe advances together; a stalled output freezes every stage.
    assign w_en         = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = w_en;

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            w_p[k] = r_x[k][k*BLK +: BLK] ^ r_y[k][k*BLK +: BLK];
            w_g[k] = r_x[k][k*BLK +: BLK] & r_y[k][k*BLK +: BLK];
            w_c[k] = cla_carries(w_p[k], w_g[k], r_c[k]);
            w_s[k] = r_s[k];
            w_s[k][k*BLK +: BLK] = w_p[k] ^ w_c[k][BLK-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_c   <= '0;
            r_ov  <= 1'b0;
            r_z   <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                r_x[k] <= '0;
                r_y[k] <= '0;
            end
            for (int k = 0; k <= NSTG; k++) r_s[k] <= '0;
        end else if (w_en) begin
            r_vld[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_x[0] <= bus.X;
                r_y[0] <= bus.SUB ? ~bus.Y : bus.Y;
                r_c[0] <= bus.SUB | bus.C0;
                r_s[0] <= '0;
            end
            // Data registers load only for real operations, so bubbles leave outputs untouched.
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k+1] <= r_vld[k];
                if (r_vld[k]) begin
                    r_s[k+1] <= w_s[k];
                    r_c[k+1] <= w_c[k][BLK];
                end
            end
            for (int k = 0; k < NSTG - 1; k++) begin
                if (r_vld[k]) begin
                    r_x[k+1] <= r_x[k];
                    r_y[k+1] <= r_y[k];
                end
            end
            if (r_vld[NSTG-1]) begin
                r_ov <= w_c[NSTG-1][BLK-1] ^ w_c[NSTG-1][BLK];
                r_z  <= ~|w_s[NSTG-1];
            end
        end
    end

    assign bus.out_valid = r_vld[NSTG];
    assign bus.S         = r_s[NSTG];
    assign bus.CO        = r_c[NSTG];
    assign bus.OV        = r_ov;
    assign bus.Z         = r_z;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (16-bit, 4-bit groups): vector table, stall burst, mid-flight reset.
module tb_pipelined_cla_adder;
    localparam int WIDTH = 16;
    localparam int BLK   = 4;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        c0;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [18:0] exp_q[$];
    logic [18:0] mon_e;
    int          errors = 0;
    int          checks = 0;
    int          n_out  = 0;
    vec_t        vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [18:0] exp_of(input vec_t v);
        return {v.s, v.co, v.ov, v.z};
    endfunction

    task automatic set_op(input vec_t v);
        bus.X   = v.x;
        bus.Y   = v.y;
        bus.C0  = v.c0;
        bus.SUB = v.sub;
    endtask

    // Scoreboard: every output handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got S=0x%0h with nothing pending", bus.S);
            end else begin
                mon_e = exp_q.pop_front();
                check("result {S,CO,OV,Z}", {13'd0, bus.S, bus.CO, bus.OV, bus.Z}, {13'd0, mon_e});
            end
        end
    end

    task automatic run_one(input vec_t v, input string name);
        int lat;
        lat = 0;
        set_op(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        exp_q.push_back(exp_of(v));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        check({name, "_latency"}, lat, 32'd4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int   acc;
        int   guard;
        int   w;
        int   n0;
        logic [15:0] s0;

        vecs[0] = '{x:16'h00FF, y:16'h0001, c0:1'b0, sub:1'b0, s:16'h0100, co:1'b0, ov:1'b0, z:1'b0};
        vecs[1] = '{x:16'hFFFF, y:16'h0001, c0:1'b0, sub:1'b0, s:16'h0000, co:1'b1, ov:1'b0, z:1'b1};
        vecs[2] = '{x:16'h7FFF, y:16'h0000, c0:1'b1, sub:1'b0, s:16'h8000, co:1'b0, ov:1'b1, z:1'b0};
        vecs[3] = '{x:16'h8000, y:16'h0001, c0:1'b1, sub:1'b1, s:16'h7FFF, co:1'b1, ov:1'b1, z:1'b0};
        vecs[4] = '{x:16'h0001, y:16'h0002, c0:1'b0, sub:1'b1, s:16'hFFFF, co:1'b0, ov:1'b0, z:1'b0};
        vecs[5] = '{x:16'h1234, y:16'h4321, c0:1'b0, sub:1'b0, s:16'h5555, co:1'b0, ov:1'b0, z:1'b0};
        vecs[6] = '{x:16'h5555, y:16'h5555, c0:1'b0, sub:1'b1, s:16'h0000, co:1'b1, ov:1'b0, z:1'b1};
        vecs[7] = '{x:16'h8000, y:16'h8000, c0:1'b0, sub:1'b0, s:16'h0000, co:1'b1, ov:1'b1, z:1'b1};
        vecs[8] = '{x:16'hABCD, y:16'h1234, c0:1'b1, sub:1'b0, s:16'hBE02, co:1'b0, ov:1'b0, z:1'b0};
        vecs[9] = '{x:16'h0000, y:16'h0001, c0:1'b0, sub:1'b1, s:16'hFFFF, co:1'b0, ov:1'b0, z:1'b0};

        // Reset
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_op(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_S",         {16'd0, bus.S},         32'd0);
        check("rst_CO",        {31'd0, bus.CO},        32'd0);
        check("rst_OV",        {31'd0, bus.OV},        32'd0);
        check("rst_Z",         {31'd0, bus.Z},         32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table, one operation at a time
        for (int i = 0; i < 10; i++) run_one(vecs[i], $sformatf("vec%0d", i));
        repeat (2) @(posedge clk);
        #1;
        check("table_drained", exp_q.size(), 32'd0);

        // Back-to-back burst with a three-cycle output stall after the first result
        n0  = n_out;
        acc = 0;
        fork
            begin
                guard = 0;
                while (acc < 6 && guard < 100) begin
                    set_op(vecs[acc]);
                    bus.in_valid = 1'b1;
                    @(negedge clk);
                    if (bus.in_ready === 1'b1) begin
                        exp_q.push_back(exp_of(vecs[acc]));
                        acc++;
                    end
                    @(posedge clk);
                    #1;
                    guard++;
                end
                bus.in_valid = 1'b0;
            end
            begin
                w = 0;
                while (bus.out_valid !== 1'b1 && w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                check("burst_first_valid", {31'd0, bus.out_valid}, 32'd1);
                s0 = bus.S;
                check("burst_first_S", {16'd0, s0}, {16'd0, vecs[0].s});
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready",  {31'd0, bus.in_ready},  32'd0);
                    check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                    check("stall_S_stable",  {16'd0, bus.S},         {16'd0, s0});
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("burst_accepted", acc, 32'd6);
        check("burst_drained", exp_q.size(), 32'd0);
        check("burst_results", n_out - n0, 32'd6);

        // Reset while three operations are in flight
        for (int i = 0; i < 3; i++) begin
            set_op(vecs[i]);
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0    = n_out;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("flush_out_valid_%0d", c), {31'd0, bus.out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        run_one(vecs[5], "post_reset");
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_results", n_out - n0, 32'd1);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's 8-bit hybrid ripple/lookahead adder.
- Splits a WIDTH-bit add/subtract into WIDTH/BLK lookahead groups, one group per pipeline stage; the group carry is registered between stages.
- Valid/ready handshake on input and output; one result per cycle when not stalled.
- Adds subtract mode and carry/overflow/zero flags; sits in the datapath as the shared integer adder.

Parameters:
- WIDTH, 16, operand and sum width; must be a multiple of BLK.
- BLK, 4, lookahead group size in bits (1..WIDTH); the number of stages NSTG = WIDTH/BLK.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept this cycle
- X  input  WIDTH  operand A
- Y  input  WIDTH  operand B
- C0  input  1  carry-in; ignored when SUB=1
- SUB  input  1  1: X-Y, 0: X+Y+C0
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum/difference
- CO  output  1  carry out of MSB (SUB: 1 = no borrow)
- OV  output  1  signed overflow
- Z  output  1  S == 0

Behaviour:
- Reset (rst_n=0 at clock edge): all stage valid bits and out_valid = 0. S, CO, OV and Z = 0.
  - Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Global advance: en = ~out_valid | out_ready; in_ready = en (combinational).
  - Input is accepted when in_valid & in_ready.
  - When en=0 every stage holds, including data and valid bits.
- Operand preparation at accept:
  - Yeff = SUB ? ~Y : Y.
  - cin = SUB ? 1 : C0.
- Stage k (0..NSTG-1) processes bits [k*BLK +: BLK]:
  - Per-bit P = X^Yeff, G = X&Yeff.
  - Full lookahead carries inside the group from the incoming group carry, with no ripple.
  - Sum bits S = P ^ c.
  - Registers the group carry-out for stage k+1.
- Skew handling:
  - Operand bits above the current group travel with the operation in stage registers.
  - Computed lower sum bits accumulate alongside.
  - Each stage also carries a valid bit.
- Latency: NSTG cycles from accept edge to out_valid=1 (16/4 → 4 cycles).
  - The final stage register is the output register.
  - Throughput is 1 per cycle while out_ready=1.
- Flags, computed in the last stage and registered with S:
  - CO = carry out of bit WIDTH-1.
  - OV = carry into bit WIDTH-1 XOR CO.
  - Z = ~|S.
- out_valid stays 1 and S/CO/OV/Z stay stable until out_ready=1 at a clock edge.
- Simultaneous accept and output drain in the same cycle is legal. There are no bubbles and no loss.
- Bubbles (in_valid=0) propagate as valid=0 stages. Outputs for a bubble keep their last values; only out_valid is meaningful.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - BLK=WIDTH gives a single-stage registered CLA with latency 1.
  - BLK=1 gives a fully bit-pipelined ripple adder.
- Illegal parameters (WIDTH % BLK ≠ 0) stop elaboration with an error.

Test Plan (WIDTH=16, BLK=4, out_ready=1 unless stated):
- Hold rst_n=0 for 2 cycles → out_valid=0, in_ready=1, S=0x0000, CO=0, OV=0, Z=0.
- X=0x00FF, Y=0x0001, C0=0, SUB=0 accepted at edge t → at t+4: out_valid=1, S=0x0100, CO=0, OV=0, Z=0.
- X=0xFFFF, Y=0x0001, C0=0 → S=0x0000, CO=1, OV=0, Z=1. Then X=0x7FFF, Y=0x0000, C0=1 → S=0x8000, CO=0, OV=1.
- SUB=1, X=0x8000, Y=0x0001, C0=1 (ignored) → S=0x7FFF, CO=1, OV=1. Then SUB=1, X=0x0001, Y=0x0002 → S=0xFFFF, CO=0, OV=0.
- Back-to-back burst of 6 operations with out_ready low for 3 cycles after the first result:
  - in_ready drops in the same cycle; the pipeline holds and the first result stays stable.
  - All 6 results appear in order with no duplicates once out_ready returns.
- Accept 3 operations, assert rst_n=0 for 1 cycle at t+2 → out_valid=0 thereafter. The next accepted X=0x1234, Y=0x4321 yields only S=0x5555, 4 cycles after its accept.
